// File: rtl/set_assoc_cache_if.sv
// CPU load/store, line-wide memory bus and snoop signals of set_assoc_cache.
// "slave" is the cache side; "master" is the CPU/memory environment side.
interface set_assoc_cache_if #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int WORDS_PER_LINE = 8
);
   localparam int LINE = DATA_WIDTH * WORDS_PER_LINE;

   logic                  avalid;
   logic [ADDR_WIDTH-1:0] aaddr;
   logic                  load;
   logic [DATA_WIDTH-1:0] data_from_cpu;
   logic [DATA_WIDTH-1:0] data_to_cpu;
   logic                  hit;
   logic                  command_valid;
   logic                  command_store;
   logic [ADDR_WIDTH-1:0] command_addr;
   logic [LINE-1:0]       data_to_bus;
   logic [LINE-1:0]       data_from_bus;
   logic                  bus_valid;
   logic                  bus_ready;
   logic                  invalidate;
   logic [ADDR_WIDTH-1:0] invalidate_addr;

   modport slave (
      input  avalid, aaddr, load, data_from_cpu, data_from_bus, bus_valid, bus_ready,
             invalidate, invalidate_addr,
      output data_to_cpu, hit, command_valid, command_store, command_addr, data_to_bus
   );

   modport master (
      output avalid, aaddr, load, data_from_cpu, data_from_bus, bus_valid, bus_ready,
             invalidate, invalidate_addr,
      input  data_to_cpu, hit, command_valid, command_store, command_addr, data_to_bus
   );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back cache with tree pseudo-LRU replacement,
// dirty-victim writeback before refill, and a snoop-invalidate port.
module set_assoc_cache #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int WORDS_PER_LINE = 8,
   parameter int INDEX_LENGTH   = 4,
   parameter int WAYS           = 2,
   parameter int READ_ONLY      = 0
) (
   input logic           clk,
   input logic           reset,
   set_assoc_cache_if.slave io_cif
);
   localparam int WB            = $clog2(DATA_WIDTH / 8);
   localparam int WOFF          = $clog2(WORDS_PER_LINE);
   localparam int OFFSET_LENGTH = WB + WOFF;
   localparam int LINE          = DATA_WIDTH * WORDS_PER_LINE;
   localparam int TAG_LENGTH    = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH;
   localparam int SETS          = 2 ** INDEX_LENGTH;
   localparam int LOG_WAYS      = $clog2(WAYS);
   localparam int WAYW          = (WAYS > 1) ? LOG_WAYS : 1;
   localparam int PLRU_W        = (WAYS > 1) ? WAYS - 1 : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITEBACK = 2'd1, S_FILL = 2'd2} state_t;

   // Heap-ordered tree: node n lives in bit n-1, a 0 bit steers the victim left.
   function automatic logic [WAYW-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      int node;
      node = 1;
      for (int l = 0; l < LOG_WAYS; l++) node = 2 * node + int'(bits[node-1]);
      return WAYW'(node - WAYS);
   endfunction

   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAYW-1:0]   way);
      logic [PLRU_W-1:0] res;
      logic              dir;
      int                node;
      res  = bits;
      node = 1;
      for (int l = 0; l < LOG_WAYS; l++) begin
         dir           = way[LOG_WAYS-1-l];
         res[node-1]   = ~dir;
         node          = 2 * node + int'(dir);
      end
      return res;
   endfunction

   logic [SETS-1:0]       r_valid [WAYS];
   logic [SETS-1:0]       r_dirty [WAYS];
   logic [TAG_LENGTH-1:0] r_tag   [WAYS][SETS];
   logic [LINE-1:0]       r_line  [WAYS][SETS];
   logic [PLRU_W-1:0]     r_plru  [SETS];

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_fill_addr, r_victim_addr;
   logic [WAYW-1:0]       r_victim_way;
   logic [LINE-1:0]       r_victim_line;

   logic [TAG_LENGTH-1:0]   w_tag, w_inv_tag, w_fill_tag;
   logic [INDEX_LENGTH-1:0] w_index, w_inv_index, w_fill_index;
   logic [WOFF-1:0]         w_word;
   logic [WAYS-1:0]         w_match, w_free, w_inv_match;
   logic                    w_hit_any, w_free_any, w_hit, w_miss, w_store, w_victim_dirty;
   logic [WAYW-1:0]         w_hit_way, w_free_way, w_victim_way;
   logic [LINE-1:0]         w_fill_line;
   logic                    w_fill_done;
   logic                    w_unused;

   assign w_tag        = io_cif.aaddr[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign w_index      = io_cif.aaddr[OFFSET_LENGTH +: INDEX_LENGTH];
   assign w_word       = io_cif.aaddr[WB +: WOFF];
   assign w_inv_tag    = io_cif.invalidate_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign w_inv_index  = io_cif.invalidate_addr[OFFSET_LENGTH +: INDEX_LENGTH];
   assign w_fill_tag   = r_fill_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign w_fill_index = r_fill_addr[OFFSET_LENGTH +: INDEX_LENGTH];
   assign w_unused     = ^{io_cif.aaddr[WB-1:0], io_cif.invalidate_addr[OFFSET_LENGTH-1:0],
                           r_fill_addr[OFFSET_LENGTH-1:0]};

   // Tag compare, lowest free way and snoop match for the addressed sets.
   always_comb begin
      w_hit_way  = '0;
      w_free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         w_match[w]     = r_valid[w][w_index] && (r_tag[w][w_index] == w_tag);
         w_free[w]      = !r_valid[w][w_index];
         w_inv_match[w] = r_valid[w][w_inv_index] && (r_tag[w][w_inv_index] == w_inv_tag);
         w_hit_way      = w_match[w] ? WAYW'(w) : w_hit_way;
         w_free_way     = w_free[w] ? WAYW'(w) : w_free_way;
      end
      w_hit_any      = |w_match;
      w_free_any     = |w_free;
      w_victim_way   = w_free_any ? w_free_way : plru_victim(r_plru[w_index]);
      w_victim_dirty = r_valid[w_victim_way][w_index] && r_dirty[w_victim_way][w_index];
   end

   assign w_store     = !io_cif.load && (READ_ONLY == 0);
   assign w_hit       = io_cif.avalid && !io_cif.invalidate && w_hit_any && (r_state == S_IDLE);
   assign w_miss      = io_cif.avalid && !io_cif.invalidate && !w_hit_any && (r_state == S_IDLE);
   assign w_fill_done = (r_state == S_FILL) && io_cif.bus_valid;

   // Refill line, with the pending store word merged in.
   always_comb begin
      w_fill_line = io_cif.data_from_bus;
      if (w_store) begin
         w_fill_line[int'(w_word)*DATA_WIDTH +: DATA_WIDTH] = io_cif.data_from_cpu;
      end else begin
         w_fill_line = io_cif.data_from_bus;
      end
   end

   // Next-state and bus command decode.
   always_comb begin
      w_state_next         = r_state;
      io_cif.command_valid = 1'b0;
      io_cif.command_store = 1'b0;
      io_cif.command_addr  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_miss) begin
               w_state_next = w_victim_dirty ? S_WRITEBACK : S_FILL;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_WRITEBACK: begin
            io_cif.command_valid = 1'b1;
            io_cif.command_store = 1'b1;
            io_cif.command_addr  = r_victim_addr;
            if (io_cif.bus_ready) begin
               w_state_next = S_FILL;
            end else begin
               w_state_next = S_WRITEBACK;
            end
         end
         S_FILL: begin
            io_cif.command_valid = 1'b1;
            io_cif.command_addr  = r_fill_addr;
            if (io_cif.bus_valid) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_FILL;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign io_cif.hit         = w_hit;
   assign io_cif.data_to_cpu = r_line[w_hit_way][w_index][int'(w_word)*DATA_WIDTH +: DATA_WIDTH];
   assign io_cif.data_to_bus = r_victim_line;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Miss bookkeeping: victim way, its line/address, and the refill address.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_victim_way  <= '0;
         r_victim_line <= '0;
         r_victim_addr <= '0;
         r_fill_addr   <= '0;
      end else if (w_miss) begin
         r_victim_way  <= w_victim_way;
         r_victim_line <= r_line[w_victim_way][w_index];
         r_victim_addr <= {r_tag[w_victim_way][w_index], w_index, {OFFSET_LENGTH{1'b0}}};
         r_fill_addr   <= {w_tag, w_index, {OFFSET_LENGTH{1'b0}}};
      end
   end

   // Valid/dirty/PLRU state; a refill is written after the snoop so it wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < WAYS; w++) begin
            r_valid[w] <= '0;
            r_dirty[w] <= '0;
         end
         for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
      end else begin
         if (w_hit) begin
            r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
            if (w_store) r_dirty[w_hit_way][w_index] <= 1'b1;
         end
         for (int w = 0; w < WAYS; w++) begin
            if (io_cif.invalidate && w_inv_match[w]) begin
               r_valid[w][w_inv_index] <= 1'b0;
               r_dirty[w][w_inv_index] <= 1'b0;
            end
         end
         if (w_fill_done) begin
            r_valid[r_victim_way][w_fill_index] <= 1'b1;
            r_dirty[r_victim_way][w_fill_index] <= w_store;
            r_plru[w_fill_index] <= plru_touch(r_plru[w_fill_index], r_victim_way);
         end
      end
   end

   // Tag and line storage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_hit && w_store) begin
            r_line[w_hit_way][w_index][int'(w_word)*DATA_WIDTH +: DATA_WIDTH] <= io_cif.data_from_cpu;
         end
         if (w_fill_done) begin
            r_line[r_victim_way][w_fill_index] <= w_fill_line;
            r_tag[r_victim_way][w_fill_index]  <= w_fill_tag;
         end
      end
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: a write-back instance and a read-only instance.
module tb_set_assoc_cache;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   set_assoc_cache_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .WORDS_PER_LINE(8)) c ();
   set_assoc_cache_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .WORDS_PER_LINE(8)) r ();

   set_assoc_cache #(.READ_ONLY(0)) dut (.clk(clk), .reset(reset), .io_cif(c.slave));
   set_assoc_cache #(.READ_ONLY(1)) dut_ro (.clk(clk), .reset(reset), .io_cif(r.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line whose word 0 is w0 and word i (i>0) is base+i.
   function automatic logic [511:0] mk_line(input logic [63:0] w0, input logic [63:0] base);
      logic [511:0] l;
      for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
      l[63:0] = w0;
      return l;
   endfunction

   initial begin
      {c.avalid, c.load, c.bus_valid, c.bus_ready, c.invalidate} = 5'd0;
      {r.avalid, r.load, r.bus_valid, r.bus_ready, r.invalidate} = 5'd0;
      c.aaddr = 64'd0; c.data_from_cpu = 64'd0; c.data_from_bus = 512'd0; c.invalidate_addr = 64'd0;
      r.aaddr = 64'd0; r.data_from_cpu = 64'd0; r.data_from_bus = 512'd0; r.invalidate_addr = 64'd0;
      repeat (2) step();
      chk("rst_cmd_valid", 64'(c.command_valid), 64'd0);
      chk("rst_cmd_store", 64'(c.command_store), 64'd0);
      chk("rst_cmd_addr", c.command_addr, 64'd0);
      chk("rst_dtb", c.data_to_bus[63:0], 64'd0);
      chk("rst_hit", 64'(c.hit), 64'd0);
      reset = 1'b0;
      step();

      // Cold load miss on 0x1000, fill, then hit.
      c.avalid = 1'b1; c.load = 1'b1; c.aaddr = 64'h1000; #1;
      chk("miss1_hit", 64'(c.hit), 64'd0);
      step();
      chk("fill1_valid", 64'(c.command_valid), 64'd1);
      chk("fill1_store", 64'(c.command_store), 64'd0);
      chk("fill1_addr", c.command_addr, 64'h1000);
      c.data_from_bus = mk_line(64'hAA, 64'h100); c.bus_valid = 1'b1;
      step();
      c.bus_valid = 1'b0; #1;
      chk("hit1", 64'(c.hit), 64'd1);
      chk("hit1_data", c.data_to_cpu, 64'hAA);

      // Store hit then load hit of the same word.
      c.load = 1'b0; c.aaddr = 64'h1008; c.data_from_cpu = 64'hDEAD; #1;
      chk("st_hit", 64'(c.hit), 64'd1);
      step();
      c.load = 1'b1; #1;
      chk("ld_after_st_hit", 64'(c.hit), 64'd1);
      chk("ld_after_st_data", c.data_to_cpu, 64'hDEAD);
      chk("ld_after_st_nocmd", 64'(c.command_valid), 64'd0);

      // Second line in set 0.
      c.aaddr = 64'h2000; #1;
      chk("miss2_hit", 64'(c.hit), 64'd0);
      step();
      chk("fill2_addr", c.command_addr, 64'h2000);
      c.data_from_bus = mk_line(64'hBB, 64'h200); c.bus_valid = 1'b1;
      step();
      c.bus_valid = 1'b0; #1;
      chk("hit2_data", c.data_to_cpu, 64'hBB);

      // Conflict miss: dirty 0x1000 is the PLRU victim and is written back first.
      c.aaddr = 64'h3000; #1;
      step();
      chk("wb_valid", 64'(c.command_valid), 64'd1);
      chk("wb_store", 64'(c.command_store), 64'd1);
      chk("wb_addr", c.command_addr, 64'h1000);
      chk("wb_word0", c.data_to_bus[63:0], 64'hAA);
      chk("wb_word1", c.data_to_bus[127:64], 64'hDEAD);
      c.bus_valid = 1'b1;
      step();
      chk("wb_ignores_bus_valid", 64'(c.command_store), 64'd1);
      c.bus_valid = 1'b0; c.bus_ready = 1'b1;
      step();
      chk("fill3_store", 64'(c.command_store), 64'd0);
      chk("fill3_addr", c.command_addr, 64'h3000);
      chk("fill3_dtb_hold", c.data_to_bus[127:64], 64'hDEAD);
      c.data_from_bus = mk_line(64'hCC, 64'h300); c.bus_valid = 1'b1;
      step();
      c.bus_valid = 1'b0; c.bus_ready = 1'b0; #1;
      chk("hit3_data", c.data_to_cpu, 64'hCC);

      // Touch 0x2000 so the clean 0x3000 way becomes the victim.
      c.aaddr = 64'h2000; #1;
      chk("touch2_data", c.data_to_cpu, 64'hBB);
      step();
      c.aaddr = 64'h1000; #1;
      chk("miss4_hit", 64'(c.hit), 64'd0);
      step();
      chk("fill4_store", 64'(c.command_store), 64'd0);
      chk("fill4_addr", c.command_addr, 64'h1000);
      c.data_from_bus = mk_line(64'hA1, 64'h400); c.bus_valid = 1'b1;
      step();
      c.bus_valid = 1'b0; #1;
      chk("hit4_data", c.data_to_cpu, 64'hA1);
      c.aaddr = 64'h2000; #1;
      chk("keep2_hit", 64'(c.hit), 64'd1);
      c.aaddr = 64'h3000; #1;
      chk("evicted3_hit", 64'(c.hit), 64'd0);
      c.avalid = 1'b0; #1;

      // Snoop invalidate together with a load of the same line stalls it.
      c.avalid = 1'b1; c.aaddr = 64'h2000; c.invalidate = 1'b1; c.invalidate_addr = 64'h2000; #1;
      chk("inv_stall_hit", 64'(c.hit), 64'd0);
      step();
      chk("inv_no_cmd", 64'(c.command_valid), 64'd0);
      c.invalidate = 1'b0; #1;
      chk("inv_then_miss", 64'(c.hit), 64'd0);
      step();
      chk("inv_fill_valid", 64'(c.command_valid), 64'd1);
      chk("inv_fill_store", 64'(c.command_store), 64'd0);
      chk("inv_fill_addr", c.command_addr, 64'h2000);
      c.data_from_bus = mk_line(64'hB2, 64'h500); c.bus_valid = 1'b1;
      c.invalidate = 1'b1; c.invalidate_addr = 64'h1000;
      step();
      c.bus_valid = 1'b0; c.invalidate = 1'b0; #1;
      chk("refill2_data", c.data_to_cpu, 64'hB2);
      c.aaddr = 64'h1000; #1;
      chk("inv_in_fill_hit", 64'(c.hit), 64'd0);
      c.avalid = 1'b0; #1;

      // Reset in the middle of a refill.
      c.avalid = 1'b1; c.aaddr = 64'h5000;
      step();
      chk("pre_rst_valid", 64'(c.command_valid), 64'd1);
      reset = 1'b1; c.avalid = 1'b0;
      step();
      chk("mid_rst_valid", 64'(c.command_valid), 64'd0);
      chk("mid_rst_addr", c.command_addr, 64'd0);
      reset = 1'b0;
      step();
      c.avalid = 1'b1; c.aaddr = 64'h2000; #1;
      chk("post_rst_hit", 64'(c.hit), 64'd0);
      c.avalid = 1'b0; #1;

      // Read-only instance: stores do not modify data, evictions never write back.
      r.avalid = 1'b1; r.load = 1'b1; r.aaddr = 64'h1000;
      step();
      chk("ro_fill_addr", r.command_addr, 64'h1000);
      r.data_from_bus = mk_line(64'hAA, 64'h100); r.bus_valid = 1'b1;
      step();
      r.bus_valid = 1'b0;
      r.load = 1'b0; r.aaddr = 64'h1008; r.data_from_cpu = 64'hDEAD; #1;
      chk("ro_st_hit", 64'(r.hit), 64'd1);
      step();
      r.load = 1'b1; #1;
      chk("ro_ld_data", r.data_to_cpu, 64'h101);
      r.aaddr = 64'h2000;
      step();
      chk("ro_fill2_addr", r.command_addr, 64'h2000);
      r.data_from_bus = mk_line(64'hBB, 64'h200); r.bus_valid = 1'b1;
      step();
      r.bus_valid = 1'b0; r.aaddr = 64'h3000;
      step();
      chk("ro_evict_valid", 64'(r.command_valid), 64'd1);
      chk("ro_evict_store", 64'(r.command_store), 64'd0);
      chk("ro_evict_addr", r.command_addr, 64'h3000);
      r.avalid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
